// File: rtl/fft_stage_ctrl_pkg.sv
// Shared definitions for the FFT stage ping-pong sequencer: bank state encodings,
// err_code bit positions and a ceil-log2 helper.
package fft_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  localparam int ERR_WR_SPURIOUS = 0;
  localparam int ERR_RD_SPURIOUS = 1;
  localparam int ERR_TIMEOUT     = 2;
  localparam int ERR_W           = 3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stage_ctrl_watchdog.sv
// Per-side watchdog: counts cycles while its side is busy and trips on the cycle
// the count would reach TIMEOUT. TIMEOUT = 0 disables tripping.
module stage_ctrl_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic busy_i,
  output logic trip_o
);

  localparam logic [TW:0] LIMIT = (TW + 1)'(TIMEOUT);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;
  logic [TW:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + (TW + 1)'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (busy_i) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Trip is raised while the increment that lands on TIMEOUT is being taken.
  assign trip_o = (TIMEOUT != 0) && busy_i && (cnt_inc == LIMIT);

endmodule

// File: rtl/stage_pingpong_ctrl.sv
// Double-buffered FFT stage sequencer: alternates two banks between loader and
// unloader, flags protocol errors. Optional err_code port: STAGE_CTRL_ERRCODE_EN.
module stage_pingpong_ctrl
  import fft_stage_ctrl_pkg::*;
#(
  parameter int N       = 16,
  parameter int TIMEOUT = 4 * N,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       wr_start,
  output logic       wr_bank,
  input  logic       wr_finished,
  input  logic       rd_ready,
  output logic       rd_start,
  output logic       rd_bank,
  input  logic       rd_finished,
  output logic [1:0] bank_full,
  output logic       error
`ifdef STAGE_CTRL_ERRCODE_EN
  ,
  output logic [2:0] err_code
`endif
);

  bank_state_e            bank_q [2];
  bank_state_e            bank_d [2];
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic                   wr_busy_q, wr_busy_d;
  logic                   rd_busy_q, rd_busy_d;
  logic                   wr_start_q, wr_start_d;
  logic                   rd_start_q, rd_start_d;
  logic [ERR_W-1:0]       err_code_q, err_code_d;

  logic wr_fin_ok, rd_fin_ok;
  logic wr_busy_mid, rd_busy_mid;
  logic wr_trip, rd_trip;

  // Finished pulses are applied first so a freed/filled bank can start next cycle.
  assign wr_fin_ok   = wr_finished && wr_busy_q;
  assign rd_fin_ok   = rd_finished && rd_busy_q;
  assign wr_busy_mid = wr_busy_q && !wr_fin_ok;
  assign rd_busy_mid = rd_busy_q && !rd_fin_ok;

  stage_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wr_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (wr_start_d),
    .busy_i  (wr_busy_mid),
    .trip_o  (wr_trip)
  );

  stage_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_rd_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (rd_start_d),
    .busy_i  (rd_busy_mid),
    .trip_o  (rd_trip)
  );

  always_comb begin
    bank_d     = bank_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_busy_d  = wr_busy_mid;
    rd_busy_d  = rd_busy_mid;
    wr_start_d = 1'b0;
    rd_start_d = 1'b0;
    err_code_d = err_code_q;

    if (wr_fin_ok) begin
      bank_d[wr_bank_q] = BANK_FULL;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_fin_ok) begin
      bank_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end

    if (wr_finished && !wr_busy_q) err_code_d[ERR_WR_SPURIOUS] = 1'b1;
    if (rd_finished && !rd_busy_q) err_code_d[ERR_RD_SPURIOUS] = 1'b1;
    if (wr_trip || rd_trip)        err_code_d[ERR_TIMEOUT]     = 1'b1;

    // A newly raised error already suppresses the start it coincides with.
    if (!wr_busy_mid && (err_code_d == '0) && (bank_d[wr_bank_d] == BANK_EMPTY)) begin
      wr_start_d        = 1'b1;
      bank_d[wr_bank_d] = BANK_FILLING;
      wr_busy_d         = 1'b1;
    end
    if (!rd_busy_mid && (err_code_d == '0) && rd_ready &&
        (bank_d[rd_bank_d] == BANK_FULL)) begin
      rd_start_d        = 1'b1;
      bank_d[rd_bank_d] = BANK_DRAINING;
      rd_busy_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0]  <= BANK_EMPTY;
      bank_q[1]  <= BANK_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_busy_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_busy_q  <= wr_busy_d;
      rd_busy_q  <= rd_busy_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
      err_code_q <= err_code_d;
    end
  end

  assign wr_start  = wr_start_q;
  assign rd_start  = rd_start_q;
  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign bank_full = {(bank_q[1] == BANK_FULL) || (bank_q[1] == BANK_DRAINING),
                      (bank_q[0] == BANK_FULL) || (bank_q[0] == BANK_DRAINING)};
  assign error     = |err_code_q;

`ifdef STAGE_CTRL_ERRCODE_EN
  assign err_code  = err_code_q;
`endif

endmodule

// File: tb/tb_stage_pingpong_ctrl.sv
// Directed bench for stage_pingpong_ctrl with a frame-order scoreboard and
// loader/unloader responders that finish 16 cycles after each start.
module tb_stage_pingpong_ctrl;

  localparam int LAT = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_start, wr_bank, wr_finished;
  logic       rd_ready;
  logic       rd_start, rd_bank, rd_finished;
  logic [1:0] bank_full;
  logic       error;
`ifdef STAGE_CTRL_ERRCODE_EN
  logic [2:0] err_code;
`endif

  stage_pingpong_ctrl #(
    .N       (16),
    .TIMEOUT (64),
    .TW      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_start    (wr_start),
    .wr_bank     (wr_bank),
    .wr_finished (wr_finished),
    .rd_ready    (rd_ready),
    .rd_start    (rd_start),
    .rd_bank     (rd_bank),
    .rd_finished (rd_finished),
    .bank_full   (bank_full),
    .error       (error)
`ifdef STAGE_CTRL_ERRCODE_EN
    ,
    .err_code    (err_code)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic sb [$];
  logic m_wr_bank, m_rd_bank, m_wr_busy, m_rd_busy;
  logic p_wr_fin, p_rd_fin;
  logic auto_wr, auto_rd;
  int   wr_left, rd_left;
  int   wr_starts, rd_starts, rd_done, sim_cnt;
  int   first_rd_cyc, second_wr_cyc, last_wr_start_cyc, last_rd_start_cyc, last_rd_fin_cyc;
  int   base, rd_cyc;
  logic exp_bank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    wr_finished = 1'b0;
    rd_finished = 1'b0;
    if (!rst_n) begin
      cyc = 0; m_wr_bank = 0; m_rd_bank = 0; m_wr_busy = 0; m_rd_busy = 0;
      wr_left = 0; rd_left = 0; p_wr_fin = 0; p_rd_fin = 0; sb.delete();
      wr_starts = 0; rd_starts = 0; rd_done = 0; sim_cnt = 0;
      first_rd_cyc = 0; second_wr_cyc = 0;
      last_wr_start_cyc = 0; last_rd_start_cyc = 0; last_rd_fin_cyc = 0;
    end else begin
      if (p_wr_fin) begin m_wr_bank = ~m_wr_bank; m_wr_busy = 0; end
      if (p_rd_fin) begin m_rd_bank = ~m_rd_bank; m_rd_busy = 0; end
      p_wr_fin = 0;
      p_rd_fin = 0;
      check("wr_bank_track", wr_bank, m_wr_bank);
      check("rd_bank_track", rd_bank, m_rd_bank);
      if (wr_start) begin
        if (m_wr_busy) check("wr_start_while_busy", wr_start, 0);
        wr_starts++;
        last_wr_start_cyc = cyc;
        if (wr_starts == 2) second_wr_cyc = cyc;
        m_wr_busy = 1;
        if (auto_wr) wr_left = LAT;
      end else if (wr_left > 0) begin
        wr_left--;
        if (wr_left == 0) begin
          wr_finished = 1'b1;
          p_wr_fin = 1;
          sb.push_back(m_wr_bank);
        end
      end
      if (rd_start) begin
        if (m_rd_busy) check("rd_start_while_busy", rd_start, 0);
        if (sb.size() == 0) begin
          check("rd_start_without_frame", rd_start, 0);
        end else begin
          exp_bank = sb.pop_front();
          check("rd_bank_order", rd_bank, exp_bank);
        end
        rd_starts++;
        last_rd_start_cyc = cyc;
        if (rd_starts == 1) first_rd_cyc = cyc;
        m_rd_busy = 1;
        if (auto_rd) rd_left = LAT;
      end else if (rd_left > 0) begin
        rd_left--;
        if (rd_left == 0) begin
          rd_finished = 1'b1;
          p_rd_fin = 1;
          rd_done++;
          last_rd_fin_cyc = cyc;
        end
      end
      if (wr_finished && rd_finished) sim_cnt++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_start"}, wr_start, 0);
    check({tag, "_rd_start"}, rd_start, 0);
    check({tag, "_wr_bank"}, wr_bank, 0);
    check({tag, "_rd_bank"}, rd_bank, 0);
    check({tag, "_bank_full"}, bank_full, 2'b00);
    check({tag, "_error"}, error, 0);
`ifdef STAGE_CTRL_ERRCODE_EN
    check({tag, "_err_code"}, err_code, 3'b000);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    rst_n = 1'b0; wr_finished = 1'b0; rd_finished = 1'b0; rd_ready = 1'b1;
    auto_wr = 1; auto_rd = 1;
    wr_left = 0; rd_left = 0; p_wr_fin = 0; p_rd_fin = 0;

    // Steady-state ping-pong over 8 frames
    do_reset();
    tick();
    check("first_wr_start", wr_start, 1);
    check("first_wr_bank", wr_bank, 0);
    for (int i = 0; i < 400 && rd_done < 8; i++) tick();
    check("frames_done", rd_done >= 8, 1);
    check("first_rd_start_cyc", first_rd_cyc, 18);
    check("second_wr_start_cyc", second_wr_cyc, 18);
    check("simultaneous_finishes_seen", sim_cnt > 0, 1);
    check("steady_error", error, 0);

    // Reader back-pressure: both banks fill, writer stalls
    rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 100 && cyc < 60; i++) tick();
    check("stall_bank_full", bank_full, 2'b11);
    check("stall_wr_starts", wr_starts, 2);
    check("stall_rd_starts", rd_starts, 0);
    rd_ready = 1'b1;
    tick();
    check("release_rd_start", rd_start, 1);
    check("release_rd_bank", rd_bank, 0);
    for (int i = 0; i < 40 && wr_starts < 3; i++) tick();
    check("refill_wr_starts", wr_starts, 3);
    check("refill_latency", last_wr_start_cyc - last_rd_fin_cyc, 1);
    check("refill_wr_bank", wr_bank, 0);
    check("refill_error", error, 0);

    // Spurious wr_finished while the writer is stalled
    rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 100 && cyc < 50; i++) tick();
    auto_wr = 0;
    check("spur_pre_error", error, 0);
    wr_finished = 1'b1;
    tick();
    check("spur_error", error, 1);
`ifdef STAGE_CTRL_ERRCODE_EN
    check("spur_err_code", err_code, 3'b001);
`endif
    rd_ready = 1'b1;
    base = wr_starts + rd_starts;
    for (int i = 0; i < 40; i++) tick();
    check("spur_no_starts", wr_starts + rd_starts, base);
    check("spur_error_sticky", error, 1);
    check("spur_bank_full", bank_full, 2'b11);

    // Watchdog: rd_finished withheld after a read starts
    auto_wr = 1; auto_rd = 0; rd_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && rd_starts == 0; i++) tick();
    check("to_rd_started", rd_starts, 1);
    rd_cyc = last_rd_start_cyc;
    for (int i = 0; i < 100 && cyc < rd_cyc + 63; i++) tick();
    check("to_before_error", error, 0);
    tick();
    check("to_error", error, 1);
    check("to_cycle", cyc - rd_cyc, 64);
`ifdef STAGE_CTRL_ERRCODE_EN
    check("to_err_code", err_code, 3'b100);
`endif

    // Reset dropped mid-fill, with finished pulses in the reset cycle
    auto_wr = 1; auto_rd = 1;
    do_reset();
    for (int i = 0; i < 10 && cyc < 5; i++) tick();
    check("midfill_busy_bank_full", bank_full, 2'b00);
    rst_n = 1'b0;
    wr_finished = 1'b1;
    rd_finished = 1'b1;
    tick();
    check_reset_vals("midreset");
    rst_n = 1'b1;
    tick();
    check("rerun_wr_start", wr_start, 1);
    check("rerun_wr_bank", wr_bank, 0);
    check("rerun_error", error, 0);
    check("rerun_bank_full", bank_full, 2'b00);
    tick();
    check("rerun_wr_start_width", wr_start, 0);
    check("rerun_rd_start", rd_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
